uart_tx: RTL and testbench

UART transmitter: serialises one parallel byte into an asynchronous frame with a start bit, DBIT data bits LSB first, optional even parity and a stop period. It is the transmit-side counterpart of the UART receive path. It is paced by the same 16x oversampling tick enable the receiver uses, from the sample-tick generator, so one bit lasts 16 ticks. It sits between the AES result/command logic, which supplies bytes, and the serial TX pin.

---
 rtl/uart_tx.sv | 149 ++++++++++++++
 tb/tb_uart_tx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional even parity, stop period.
// Paced by a 16x oversampling tick enable, so one bit lasts 16 ticks.
module uart_tx #(
  parameter int unsigned DBIT      = 8,
  parameter int unsigned SB_TICK   = 16,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(15);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(SB_TICK - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    s_cnt, s_cnt_next;
  logic [IDX_W-1:0]    n_cnt, n_cnt_next;
  logic [DATA_W-1:0]   b_reg, b_next;
  logic                p_reg, p_next;
  logic                tx_reg, tx_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  // State and datapath registers; reset abandons any frame and returns the line high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      s_cnt    <= '0;
      n_cnt    <= '0;
      b_reg    <= '0;
      p_reg    <= 1'b0;
      tx_reg   <= 1'b1;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      state    <= state_next;
      s_cnt    <= s_cnt_next;
      n_cnt    <= n_cnt_next;
      b_reg    <= b_next;
      p_reg    <= p_next;
      tx_reg   <= tx_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  // Next-state logic; outputs are computed from the next state so they change with it.
  always_comb begin
    state_next = state;
    s_cnt_next = s_cnt;
    n_cnt_next = n_cnt;
    b_next     = b_reg;
    p_next     = p_reg;
    done_next  = 1'b0;

    case (state)
      IDLE: begin
        if (tx_start) begin
          b_next     = din;
          p_next     = 1'b0;
          s_cnt_next = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            s_cnt_next = '0;
            n_cnt_next = '0;
            state_next = DATA;
          end else begin
            s_cnt_next = s_cnt + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            s_cnt_next = '0;
            p_next     = p_reg ^ b_reg[0];
            b_next     = {1'b0, b_reg[DATA_W-1:1]};
            if (n_cnt == IDX_LAST) begin
              state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              n_cnt_next = n_cnt + IDX_W'(1);
            end
          end else begin
            s_cnt_next = s_cnt + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            s_cnt_next = '0;
            state_next = STOP;
          end else begin
            s_cnt_next = s_cnt + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == STOP_LAST) begin
            s_cnt_next = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            s_cnt_next = s_cnt + CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      PARITY:  tx_next = p_next;
      default: tx_next = 1'b1;
    endcase

    busy_next = (state_next != IDLE);
  end

  assign tx           = tx_reg;
  assign tx_busy      = busy_reg;
  assign tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table of frames checked cycle by cycle against a tick-count model,
// plus reset, mid-frame reset, ignored-start and back-to-back sequences.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       tx_start0, tx_start1;
  logic [7:0] din;
  logic       tx0, busy0, done0;
  logic       tx1, busy1, done1;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start0), .din(din),
    .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0)
  );

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1)) dut_p (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start1), .din(din),
    .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       par;      // 1: use the even-parity instance
    logic [7:0] data;
    int         period;   // clk cycles per tick
    logic       exp_par;  // hand-computed parity bit
    int         len;      // hand-computed frame length in cycles
    int         inject;   // cycle of a spurious tx_start with din=0xFF (0: none)
    logic       late;     // tx_start in the last stop cycle
  } vec_t;

  localparam int NVEC      = 8;
  localparam int RESET_IDX = 7;
  vec_t vec [NVEC];

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] d;
    logic       t, b, dn, exp_tx;
    int         nbits, idx;
    d     = v.data;
    nbits = v.par ? 10 : 9;
    din   = v.data;
    if (v.par) tx_start1 = 1'b1; else tx_start0 = 1'b1;
    s_tick = 1'b0;
    @(posedge clk); #1;
    tx_start0 = 1'b0;
    tx_start1 = 1'b0;
    t  = v.par ? tx1 : tx0;
    b  = v.par ? busy1 : busy0;
    dn = v.par ? done1 : done0;
    chk("accept_tx", t, 1'b0);
    chk("accept_busy", b, 1'b1);
    chk("accept_done", dn, 1'b0);
    for (int e = 1; e <= v.len; e++) begin
      s_tick = ((e % v.period) == 0);
      if (e == v.inject || (v.late && e == v.len)) begin
        din = 8'hFF;
        if (v.par) tx_start1 = 1'b1; else tx_start0 = 1'b1;
      end else begin
        tx_start0 = 1'b0;
        tx_start1 = 1'b0;
      end
      @(posedge clk); #1;
      t  = v.par ? tx1 : tx0;
      b  = v.par ? busy1 : busy0;
      dn = v.par ? done1 : done0;
      idx = (e / v.period) / 16;
      if (e == v.len) begin
        chk("end_tx", t, 1'b1);
        chk("end_busy", b, 1'b0);
        chk("end_done", dn, 1'b1);
      end else begin
        if (idx == 0)                      exp_tx = 1'b0;
        else if (idx <= 8)                 exp_tx = d[idx-1];
        else if (v.par && idx == nbits-1)  exp_tx = v.exp_par;
        else                               exp_tx = 1'b1;
        chk("frame_tx", t, exp_tx);
        chk("frame_busy", b, 1'b1);
        chk("frame_done", dn, 1'b0);
      end
    end
    tx_start0 = 1'b0;
    tx_start1 = 1'b0;
    s_tick    = 1'b0;
    if (v.late) begin
      @(posedge clk); #1;
      t  = v.par ? tx1 : tx0;
      b  = v.par ? busy1 : busy0;
      dn = v.par ? done1 : done0;
      chk("late_start_ignored_busy", b, 1'b0);
      chk("late_start_ignored_tx", t, 1'b1);
      chk("late_done_single", dn, 1'b0);
    end
  endtask

  task automatic mid_reset();
    din       = 8'h52;
    tx_start0 = 1'b1;
    s_tick    = 1'b1;
    @(posedge clk); #1;
    tx_start0 = 1'b0;
    for (int e = 1; e <= 72; e++) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_data3", tx0, 1'b0);
    chk("pre_reset_busy", busy0, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset_tx", tx0, 1'b1);
    chk("async_reset_busy", busy0, 1'b0);
    chk("async_reset_done", done0, 1'b0);
    @(posedge clk); #1;
    reset  = 1'b1;
    s_tick = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_tx", tx0, 1'b1);
    chk("post_reset_busy", busy0, 1'b0);
  endtask

  initial begin
    vec[0] = '{1'b0, 8'hA5, 1, 1'b0, 160,  50, 1'b0};
    vec[1] = '{1'b0, 8'h3C, 4, 1'b0, 640,   0, 1'b1};
    vec[2] = '{1'b1, 8'h07, 1, 1'b1, 176,   0, 1'b0};
    vec[3] = '{1'b1, 8'h03, 1, 1'b0, 176,   0, 1'b0};
    vec[4] = '{1'b0, 8'h00, 2, 1'b0, 320,   0, 1'b0};
    vec[5] = '{1'b1, 8'hFF, 1, 1'b0, 176, 100, 1'b0};
    vec[6] = '{1'b1, 8'h80, 3, 1'b1, 528,   0, 1'b0};
    vec[7] = '{1'b0, 8'h55, 1, 1'b0, 160,   0, 1'b0};

    reset     = 1'b0;
    s_tick    = 1'b0;
    tx_start0 = 1'b0;
    tx_start1 = 1'b0;
    din       = 8'h00;
    #2;
    for (int i = 0; i < 20; i++) begin
      s_tick    = 1'($urandom_range(0, 1));
      tx_start0 = 1'($urandom_range(0, 1));
      tx_start1 = 1'($urandom_range(0, 1));
      din       = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      chk("rst_tx", tx0, 1'b1);
      chk("rst_busy", busy0, 1'b0);
      chk("rst_done", done0, 1'b0);
      chk("rst_tx_p", tx1, 1'b1);
      chk("rst_busy_p", busy1, 1'b0);
      chk("rst_done_p", done1, 1'b0);
    end
    s_tick    = 1'b0;
    tx_start0 = 1'b0;
    tx_start1 = 1'b0;
    reset     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_tx", tx0, 1'b1);
      chk("idle_busy", busy0, 1'b0);
      chk("idle_tx_p", tx1, 1'b1);
      chk("idle_busy_p", busy1, 1'b0);
    end

    for (int i = 0; i < NVEC; i++) begin
      if (i == RESET_IDX) mid_reset();
      run_frame(vec[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
